// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the I-side and D-side request ports, the shared memory bus and the
// per-side response/completion returns that the memory bus arbiter sits
// between. The arbiter connects through the slave modport. Whatever drives
// the requests and models memory connects through the master modport.
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int TAG_W = 4
);

   // I-side request (icache controller)
   logic [1:0]       proc2Imem_command;
   logic [31:0]      proc2Imem_addr;

   // D-side request (dcache / LSQ miss path)
   logic [1:0]       proc2Dmem_command;
   logic [31:0]      proc2Dmem_addr;
   logic [63:0]      proc2Dmem_data;

   // Memory side returns
   logic [TAG_W-1:0] mem2proc_response;
   logic [TAG_W-1:0] mem2proc_tag;
   logic [63:0]      mem2proc_data;

   // Shared processor-to-memory bus
   logic [1:0]       proc2mem_command;
   logic [31:0]      proc2mem_addr;
   logic [63:0]      proc2mem_data;

   // Per-side returns
   logic [TAG_W-1:0] Imem2proc_response;
   logic [TAG_W-1:0] Imem2proc_tag;
   logic [63:0]      Imem2proc_data;
   logic [TAG_W-1:0] Dmem2proc_response;
   logic [TAG_W-1:0] Dmem2proc_tag;
   logic [63:0]      Dmem2proc_data;

   // Completion tag arrived with no recorded owner
   logic             arb_tag_err;

   modport slave (
      input  proc2Imem_command, proc2Imem_addr,
      input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      input  mem2proc_response, mem2proc_tag, mem2proc_data,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
      output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
      output arb_tag_err
   );

   modport master (
      output proc2Imem_command, proc2Imem_addr,
      output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      output mem2proc_response, mem2proc_tag, mem2proc_data,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
      input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
      input  arb_tag_err
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates the I-side and D-side memory requests onto one processor-memory
// bus. The grant is combinational. D wins ties unless the I-side has been
// starved for STARVE_LIMIT consecutive cycles. The accept tag goes back only
// to the granted side. A tag ownership table routes each load completion back
// to the side that issued it. Unowned completions raise arb_tag_err for that
// cycle.
//
// Optional build macro: MEM_ARB_STATS_EN
//   When defined, the module has three extra outputs carrying wrapping
//   32-bit counters: accepted I grants, accepted D grants and forced
//   (starvation override) grants.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,   // 1..15
   parameter int TAG_W        = 4    // must match the interface TAG_W
) (
   input  logic               clock,
   input  logic               reset,
   mem_bus_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]        arb_i_grants,
   output logic [31:0]        arb_d_grants,
   output logic [31:0]        arb_forced_grants
`endif
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam int         N_TAGS    = 1 << TAG_W;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [3:0]        starve_q, starve_d;
   logic [N_TAGS-1:0] valid_q,  valid_d;
   logic [N_TAGS-1:0] owner_q,  owner_d;   // 0 = I side, 1 = D side

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic i_req, d_req;
   logic force_i;
   logic grant_i, grant_d;
   logic resp_nz;
   logic load_accept;
   logic tag_nz;
   logic cpl_valid;
   logic cpl_hit;
   logic cpl_owner;

   // Grant decision, bus forwarding, response and completion routing
   always_comb begin
      i_req     = (bus.proc2Imem_command != BUS_NONE);
      d_req     = (bus.proc2Dmem_command != BUS_NONE);

      // Starvation override only matters when both sides contend
      force_i   = i_req && d_req && (starve_q >= 4'(STARVE_LIMIT));
      grant_i   = i_req && (!d_req || force_i);
      grant_d   = d_req && !grant_i;

      resp_nz   = (bus.mem2proc_response != '0);
      tag_nz    = (bus.mem2proc_tag != '0);
      cpl_valid = valid_q[bus.mem2proc_tag];
      cpl_owner = owner_q[bus.mem2proc_tag];
      cpl_hit   = tag_nz && cpl_valid;

      // Bus side: forward the granted request unchanged
      bus.proc2mem_command = BUS_NONE;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      if (grant_i) begin
         bus.proc2mem_command = bus.proc2Imem_command;
         bus.proc2mem_addr    = bus.proc2Imem_addr;
      end else if (grant_d) begin
         bus.proc2mem_command = bus.proc2Dmem_command;
         bus.proc2mem_addr    = bus.proc2Dmem_addr;
         bus.proc2mem_data    = bus.proc2Dmem_data;
      end

      // Only loads produce a completion, so only load accepts are recorded
      load_accept = (grant_i || grant_d) && resp_nz &&
                    (bus.proc2mem_command == BUS_LOAD);

      // Accept tag to the granted side only. A zero tells the other side to retry.
      bus.Imem2proc_response = grant_i ? bus.mem2proc_response : '0;
      bus.Dmem2proc_response = grant_d ? bus.mem2proc_response : '0;

      // Completion tag to its recorded owner only
      bus.Imem2proc_tag = (cpl_hit && !cpl_owner) ? bus.mem2proc_tag : '0;
      bus.Dmem2proc_tag = (cpl_hit &&  cpl_owner) ? bus.mem2proc_tag : '0;
      bus.arb_tag_err   = tag_nz && !cpl_valid;

      // Data is broadcast. The tag qualifies it on each side.
      bus.Imem2proc_data = bus.mem2proc_data;
      bus.Dmem2proc_data = bus.mem2proc_data;
   end

   // Starvation count: consecutive cycles I asked and lost
   always_comb begin
      starve_d = '0;
      if (i_req && !grant_i)
         starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
   end

   // ------------------------------------------------------------------
   // Tag ownership table next-state, one slice per tag. A new accept
   // outranks a completion of the same tag in the same cycle, so a
   // reissued tag stays valid under its new owner.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_TAGS; gi++) begin : g_tag
         logic set_hit;
         logic clr_hit;
         assign set_hit = load_accept &&
                          (bus.mem2proc_response == TAG_W'(gi));
         assign clr_hit = cpl_hit && (bus.mem2proc_tag == TAG_W'(gi));
         assign valid_d[gi] = set_hit ? 1'b1 :
                              clr_hit ? 1'b0 : valid_q[gi];
         assign owner_d[gi] = set_hit ? grant_d : owner_q[gi];
      end
   endgenerate

   // Register starvation count and ownership table. Reset drops all ownership.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
         valid_q  <= '0;
         owner_q  <= '0;
      end else begin
         starve_q <= starve_d;
         valid_q  <= valid_d;
         owner_q  <= owner_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] i_grants_q, d_grants_q, forced_grants_q;

   // Wrapping grant statistics: accepted grants per side and forced I wins
   always_ff @(posedge clock) begin
      if (reset) begin
         i_grants_q      <= '0;
         d_grants_q      <= '0;
         forced_grants_q <= '0;
      end else begin
         if (grant_i && resp_nz) i_grants_q <= i_grants_q + 32'd1;
         if (grant_d && resp_nz) d_grants_q <= d_grants_q + 32'd1;
         if (force_i)            forced_grants_q <= forced_grants_q + 32'd1;
      end
   end

   assign arb_i_grants      = i_grants_q;
   assign arb_d_grants      = d_grants_q;
   assign arb_forced_grants = forced_grants_q;
`endif

endmodule
